ip_field_rep_rate: RTL and testbench



---
 rtl/ip_field_rep_rate_if.sv | 14 +
 rtl/ip_field_rep_rate.sv | 103 ++++++++++
 tb/tb_ip_field_rep_rate.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ip_field_rep_rate_if.sv
// Sample-stream / result bundle between the field extractor, the estimator and its consumers.
interface ip_field_rep_rate_if #(
  parameter int N_BITS      = 16,
  parameter int WINDOW_LOG2 = 10
);
  logic                   clear;
  logic                   valid;
  logic [N_BITS-1:0]      field;
  logic [WINDOW_LOG2:0]   rep_rate;
  logic                   ready;

  modport master (output clear, valid, field, input rep_rate, ready);
  modport slave  (input clear, valid, field, output rep_rate, ready);
endinterface

// File: rtl/ip_field_rep_rate.sv
// Per-frame repeat counter for one header field against a DEPTH-entry history of recent samples.
// Optional SEACCOW_REP_EXCL_ZERO_EN: zero samples never hit and never enter history.
module ip_field_rep_rate #(
  parameter int N_BITS      = 16,
  parameter int DEPTH       = 8,
  parameter int WINDOW_LOG2 = 10
) (
  input  logic             sys_clk,
  input  logic             reset,
  ip_field_rep_rate_if.slave bus
);
  localparam int W_ACC = WINDOW_LOG2 + 1;

  logic [DEPTH-1:0]             r_occ;
  logic [DEPTH-1:0][N_BITS-1:0] r_hist;
  logic [WINDOW_LOG2-1:0]       r_cnt;
  logic                         r_accept_q;
  logic                         r_hit_q;
  logic                         r_last_q;
  logic [W_ACC-1:0]             r_acc;
  logic [W_ACC-1:0]             r_rep_rate;
  logic [W_ACC-1:0]             r_rep_prev;
  logic                         r_ready;

  logic [DEPTH-1:0] w_match;
  logic             w_zero;
  logic             w_accept;
  logic             w_shift;
  logic             w_hit;
  logic             w_inc;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_match[g] = r_occ[g] && (r_hist[g] == bus.field);
  end

`ifdef SEACCOW_REP_EXCL_ZERO_EN
  assign w_zero = (bus.field == '0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_accept = bus.valid & ~bus.clear;
  assign w_shift  = w_accept & ~w_zero;
  assign w_hit    = w_shift & (|w_match);
  assign w_inc    = r_accept_q & r_hit_q;

  always_ff @(posedge sys_clk) begin
    if (reset || bus.clear) begin
      r_occ <= '0;
    end else if (w_shift) begin
      for (int i = DEPTH - 1; i > 0; i--) r_occ[i] <= r_occ[i-1];
      r_occ[0] <= 1'b1;
    end
  end

  // Values need no reset: the occupied bits alone decide whether an entry can match.
  always_ff @(posedge sys_clk) begin
    if (w_shift) begin
      for (int i = DEPTH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
      r_hist[0] <= bus.field;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset || bus.clear) begin
      r_cnt      <= '0;
      r_accept_q <= 1'b0;
      r_hit_q    <= 1'b0;
      r_last_q   <= 1'b0;
    end else begin
      r_accept_q <= w_accept;
      r_hit_q    <= w_hit;
      r_last_q   <= w_accept & (&r_cnt);
      if (w_accept) r_cnt <= r_cnt + WINDOW_LOG2'(1);
    end
  end

  // r_rep_prev lets a clear that lands on the pulse cycle withdraw the update it hides.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_rep_rate <= '0;
      r_rep_prev <= '0;
      r_ready    <= 1'b0;
    end else if (bus.clear) begin
      r_acc   <= '0;
      r_ready <= 1'b0;
      if (r_ready) r_rep_rate <= r_rep_prev;
    end else begin
      r_ready <= r_last_q;
      if (r_last_q) begin
        r_rep_prev <= r_rep_rate;
        r_rep_rate <= r_acc + W_ACC'(w_inc);
        r_acc      <= '0;
      end else begin
        r_acc <= r_acc + W_ACC'(w_inc);
      end
    end
  end

  assign bus.ready    = r_ready & ~bus.clear;
  assign bus.rep_rate = (r_ready & bus.clear) ? r_rep_prev : r_rep_rate;
endmodule

// File: tb/tb_ip_field_rep_rate.sv
// Randomized + directed scoreboard bench for ip_field_rep_rate (DEPTH=4, 8-sample frames).
module tb_ip_field_rep_rate;
  localparam int N = 16;
  localparam int D = 4;
  localparam int W = 3;
  localparam int FRAME = 1 << W;

  logic sys_clk = 1'b0;
  logic reset;
  int   cyc = 0;
  bit   started = 1'b0;

  ip_field_rep_rate_if #(.N_BITS(N), .WINDOW_LOG2(W)) bus ();

  ip_field_rep_rate #(.N_BITS(N), .DEPTH(D), .WINDOW_LOG2(W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  typedef struct { int due; int val; } exp_t;
  exp_t sb[$];

  int hist_q[$];
  int m_cnt  = 0;
  int m_hits = 0;
  int m_rep  = 0;
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference: history is simply the list of the last D inserted values, newest first.
  task automatic model(input bit v, input int f, input bit c, input bit r);
    bit hit, zero;
    if (r || c) begin
      hist_q.delete();
      m_cnt  = 0;
      m_hits = 0;
      sb.delete();
    end else if (v) begin
      hit  = 1'b0;
      zero = 1'b0;
`ifdef SEACCOW_REP_EXCL_ZERO_EN
      zero = (f == 0);
`endif
      if (!zero) begin
        foreach (hist_q[i]) if (hist_q[i] == f) hit = 1'b1;
        hist_q.push_front(f);
        if (hist_q.size() > D) void'(hist_q.pop_back());
      end
      m_hits += int'(hit);
      m_cnt++;
      if (m_cnt == FRAME) begin
        sb.push_back('{due: cyc + 2, val: m_hits});
        m_cnt  = 0;
        m_hits = 0;
      end
    end
  endtask

  task automatic step(input bit v, input int f, input bit c, input bit r);
    @(posedge sys_clk);
    #1;
    reset     = r;
    bus.valid = v;
    bus.field = N'(f);
    bus.clear = c;
    model(v, f, c, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (started) begin
      if (reset) begin
        m_rep = 0;
      end else if (bus.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ready_cycle", cyc, e.due);
          chk("rep_rate", int'(bus.rep_rate), e.val);
          m_rep = e.val;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("missing_ready", 0, 1);
          void'(sb.pop_front());
        end
        chk("rep_hold", int'(bus.rep_rate), m_rep);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.clear = 1'b0;
    bus.field = '0;
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    started = 1'b1;
    idle(2);

    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 8; i++) step(1'b1, 'h1234, 1'b0, 1'b0);
    idle(4);
    begin
      int seq [8] = '{1, 2, 3, 4, 1, 5, 2, 9};
      foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0);
    end
    idle(4);
    for (int i = 0; i < 5; i++) step(1'b1, 'h55, 1'b0, 1'b0);
    step(1'b1, 'h55, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 'h55, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 'h1234, 1'b0, 1'b0);
      idle(2);
    end
    idle(3);
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b0, 1'b0);
    idle(4);

    // clear one and two cycles after a frame's last sample
    for (int i = 0; i < 8; i++) step(1'b1, 7, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 8; i++) step(1'b1, 7, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(3);

    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1);
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 70, int'($urandom_range(0, 5)),
           $urandom_range(0, 199) < 3, $urandom_range(0, 999) < 2);
    end
    idle(6);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
